// File: rtl/maxpool_pkg.sv
// Shared definitions for the stride-2 / size-2 sequence max-pool.
// Latency: n/a (types, sizing helpers and the combinational per-channel max).
// Backpressure: n/a.
//
// Contents:
//   calc_out_tp  - output samples per output cycle for a given input THROUGHPUT
//   calc_out_len - pooled image length (outputs per image)
//   smax_bw      - per-channel signed max of two packed sample vectors
package maxpool_pkg;

  // Widest sample vector smax_bw handles (NO_CH*BW), widest channel and
  // largest channel count.
  localparam int MAX_W  = 512;
  localparam int MAX_BW = 32;
  localparam int MAX_CH = 64;

  // THROUGHPUT==1 pairs samples across cycles; wider inputs pair adjacent lanes.
  function automatic int calc_out_tp(input int tp);
    return (tp >= 2) ? tp / 2 : 1;
  endfunction

  function automatic int calc_out_len(input int log2_img);
    return 1 << (log2_img - 1);
  endfunction

  // Per-channel two's-complement max of nch fields of bw bits. Each field is
  // sign-extended to MAX_BW before comparing, so the compare is a plain signed
  // compare and the selected field is copied through unchanged (no growth).
  function automatic logic [MAX_W-1:0] smax_bw(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int nch,
                                               input int bw);
    logic [MAX_W-1:0]         r;
    logic signed [MAX_BW-1:0] fa;
    logic signed [MAX_BW-1:0] fb;
    int                       base;
    int                       idx;
    r = '0;
    for (int c = 0; c < MAX_CH; c++) begin
      fa = '0;
      fb = '0;
      if (c < nch) begin
        base = c * bw;
        for (int i = 0; i < MAX_BW; i++) begin
          // bits above the field repeat the field's sign bit
          idx = base + ((i < bw) ? i : bw - 1);
          if (idx < MAX_W) begin
            fa[i] = a[idx[8:0]];
            fb[i] = b[idx[8:0]];
          end
        end
        for (int i = 0; i < MAX_BW; i++) begin
          idx = base + i;
          if (i < bw && idx < MAX_W) begin
            r[idx[8:0]] = (fa >= fb) ? a[idx[8:0]] : b[idx[8:0]];
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/maxpool_stream_chan_max2.sv
// Two-input per-channel signed max for one sample pair.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   a, b - two samples, NO_CH fields of BW signed bits, channel c at [c*BW +: BW]
//   y    - per-channel max(a, b)
module chan_max2
  import maxpool_pkg::*;
#(
  parameter int NO_CH = 8,
  parameter int BW    = 4
) (
  input  logic [NO_CH*BW-1:0] a,
  input  logic [NO_CH*BW-1:0] b,
  output logic [NO_CH*BW-1:0] y
);

  // NO_CH*BW must not exceed MAX_W; the vectors are padded up to the
  // function's fixed width and the result cut back down.
  localparam int SW = NO_CH * BW;

  assign y = SW'(smax_bw(MAX_W'(a), MAX_W'(b), NO_CH, BW));

endmodule

// File: rtl/maxpool_stream.sv
// Stride-2 size-2 max-pool along the sequence axis; halves an image stream.
// Latency: 1 cycle after the second sample of each pair (same-cycle pair when THROUGHPUT>=2).
// Backpressure: none; vld_out pulses once per result and must be taken every cycle.
//
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   vld_in    - data_in carries THROUGHPUT new samples this cycle
//   data_in   - THROUGHPUT lanes, lane THROUGHPUT-1 earliest, channel c at [c*BW +: BW]
//   vld_out   - data_out carries OUT_TP pooled samples (one-cycle pulse)
//   data_out  - OUT_TP lanes, lane OUT_TP-1 earliest; holds value while vld_out=0
//   last_out  - with vld_out on the final pooled output cycle of an image
module maxpool_stream
  import maxpool_pkg::*;
#(
  parameter  int NO_CH         = 8,
  parameter  int BW            = 4,
  parameter  int LOG2_IMG_SIZE = 7,
  parameter  int THROUGHPUT    = 1,
  localparam int OUT_TP        = calc_out_tp(THROUGHPUT)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 vld_in,
  input  logic [THROUGHPUT-1:0][NO_CH*BW-1:0]  data_in,
  output logic                                 vld_out,
  output logic [OUT_TP-1:0][NO_CH*BW-1:0]      data_out,
  output logic                                 last_out
);

  localparam int SW      = NO_CH * BW;
  localparam int OUT_LEN = calc_out_len(LOG2_IMG_SIZE);
  localparam int CW      = (LOG2_IMG_SIZE > 1) ? LOG2_IMG_SIZE - 1 : 1;

  logic [CW-1:0]             out_cnt;   // pooled samples emitted so far in this image
  logic [CW:0]               cnt_sum;   // one bit wider so the wrap compare cannot overflow
  logic                      cnt_wrap;  // this output reaches the end of the image
  logic                      fire;      // a pooled result is produced at this edge
  logic [OUT_TP-1:0][SW-1:0] pool_res;

  assign cnt_sum  = {1'b0, out_cnt} + (CW+1)'(OUT_TP);
  assign cnt_wrap = (cnt_sum >= (CW+1)'(OUT_LEN));

  generate
    if (THROUGHPUT == 1) begin : g_tp1
      // One sample per cycle: pairs are formed across cycles through a hold
      // register. Phase and hold only move on vld_in, so gaps anywhere,
      // including inside a pair, are transparent.
      logic          phase;
      logic [SW-1:0] hold;

      assign fire = vld_in & phase;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          phase <= 1'b0;
          hold  <= '0;
        end else if (vld_in) begin
          if (!phase) begin
            hold <= data_in[0];
          end
          // Images are even length so the wrapping output always sits on
          // phase 1 and the toggle already returns to 0; forcing it keeps a
          // pair from ever straddling two images.
          phase <= (fire && cnt_wrap) ? 1'b0 : ~phase;
        end
      end

      chan_max2 #(
        .NO_CH (NO_CH),
        .BW    (BW)
      ) u_max (
        .a (hold),
        .b (data_in[0]),
        .y (pool_res[0])
      );
    end else begin : g_tpn
      // Even lane count: every input cycle is a whole number of pairs, so the
      // only state is the position counter.
      assign fire = vld_in;

      for (genvar k = 0; k < OUT_TP; k++) begin : g_lane
        chan_max2 #(
          .NO_CH (NO_CH),
          .BW    (BW)
        ) u_max (
          .a (data_in[2*k+1]),
          .b (data_in[2*k]),
          .y (pool_res[k])
        );
      end
    end
  endgenerate

  // Output register and position counter. A new result simply overwrites
  // data_out on the edge it is produced, so back-to-back results need no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_out  <= 1'b0;
      last_out <= 1'b0;
      data_out <= '0;
      out_cnt  <= '0;
    end else begin
      vld_out  <= fire;
      last_out <= fire & cnt_wrap;
      if (fire) begin
        data_out <= pool_res;
        out_cnt  <= cnt_wrap ? '0 : cnt_sum[CW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream across three configurations:
//   u_tp1 : THROUGHPUT=1, NO_CH=2, BW=4, LOG2_IMG_SIZE=3 (4 outputs per image)
//   u_tp4 : THROUGHPUT=4, NO_CH=2, BW=4, LOG2_IMG_SIZE=3 (2 output cycles per image)
//   u_tp2 : THROUGHPUT=2, NO_CH=2, BW=4, LOG2_IMG_SIZE=7 (64 outputs per image)
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_maxpool_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic            vld1 = 1'b0;
  logic [0:0][7:0] din1 = '0;
  logic            vo1, lo1;
  logic [0:0][7:0] dout1;

  logic            vld4 = 1'b0;
  logic [3:0][7:0] din4 = '0;
  logic            vo4, lo4;
  logic [1:0][7:0] dout4;

  logic            vld2 = 1'b0;
  logic [1:0][7:0] din2 = '0;
  logic            vo2, lo2;
  logic [0:0][7:0] dout2;

  maxpool_stream #(.NO_CH(2), .BW(4), .LOG2_IMG_SIZE(3), .THROUGHPUT(1)) u_tp1 (
    .clk(clk), .rst(rst), .vld_in(vld1), .data_in(din1),
    .vld_out(vo1), .data_out(dout1), .last_out(lo1));

  maxpool_stream #(.NO_CH(2), .BW(4), .LOG2_IMG_SIZE(3), .THROUGHPUT(4)) u_tp4 (
    .clk(clk), .rst(rst), .vld_in(vld4), .data_in(din4),
    .vld_out(vo4), .data_out(dout4), .last_out(lo4));

  maxpool_stream #(.NO_CH(2), .BW(4), .LOG2_IMG_SIZE(7), .THROUGHPUT(2)) u_tp2 (
    .clk(clk), .rst(rst), .vld_in(vld2), .data_in(din2),
    .vld_out(vo2), .data_out(dout2), .last_out(lo2));

  task automatic apply_reset();
    @(negedge clk);
    rst  = 1'b1;
    vld1 = 1'b0;
    vld4 = 1'b0;
    vld2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (vo1 !== 1'b0)   begin n_fail++; $display("FAIL reset_vo1: got %b want 0", vo1); end
    n_checks++; if (lo1 !== 1'b0)   begin n_fail++; $display("FAIL reset_lo1: got %b want 0", lo1); end
    n_checks++; if (dout1 !== 8'h0) begin n_fail++; $display("FAIL reset_dout1: got %h want 00", dout1); end
    n_checks++; if (vo4 !== 1'b0)   begin n_fail++; $display("FAIL reset_vo4: got %b want 0", vo4); end
    n_checks++; if (lo4 !== 1'b0)   begin n_fail++; $display("FAIL reset_lo4: got %b want 0", lo4); end
    n_checks++; if (dout4 !== 16'h0) begin n_fail++; $display("FAIL reset_dout4: got %h want 0000", dout4); end
    n_checks++; if (vo2 !== 1'b0)   begin n_fail++; $display("FAIL reset_vo2: got %b want 0", vo2); end
    n_checks++; if (lo2 !== 1'b0)   begin n_fail++; $display("FAIL reset_lo2: got %b want 0", lo2); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (vo1 !== 1'b0)   begin n_fail++; $display("FAIL reset_idle_vo1: got %b want 0", vo1); end
  endtask

  // ch0 sequence 1,5,-3,-7,7,-8,0,0 -> 5,-3,7,0; last on the 4th output.
  task automatic test_pairs_tp1();
    logic [7:0] seq [8];
    logic [7:0] expd [4];
    logic       exp_v;
    seq  = '{8'h01, 8'h05, 8'h0D, 8'h09, 8'h07, 8'h08, 8'h00, 8'h00};
    expd = '{8'h05, 8'h0D, 8'h07, 8'h00};
    apply_reset();
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_v = (i % 2 == 0);
        n_checks++; if (vo1 !== exp_v) begin n_fail++; $display("FAIL pairs_vld[%0d]: got %b want %b", i, vo1, exp_v); end
        n_checks++; if (lo1 !== (i == 8)) begin n_fail++; $display("FAIL pairs_last[%0d]: got %b want %b", i, lo1, (i == 8)); end
        if (exp_v) begin
          n_checks++; if (dout1[0] !== expd[i/2-1]) begin n_fail++; $display("FAIL pairs_data[%0d]: got %h want %h", i, dout1[0], expd[i/2-1]); end
        end
      end
      if (i < 8) begin vld1 = 1'b1; din1[0] = seq[i]; end
      else vld1 = 1'b0;
    end
  endtask

  // Ramp 0..7 per image, 3 images, vld_in at ~50% -> 1,3,5,7 per image.
  task automatic test_gaps();
    int         sent = 0;
    int         cyc  = 0;
    int         pimg = 0;
    logic       pv   = 1'b0;
    logic       pl   = 1'b0;
    logic [7:0] pd   = 8'h00;
    int         outs [3];
    int         lasts [3];
    for (int k = 0; k < 3; k++) begin outs[k] = 0; lasts[k] = 0; end
    apply_reset();
    while ((sent < 24 || pv) && cyc < 600) begin
      @(negedge clk);
      cyc++;
      n_checks++; if (vo1 !== pv) begin n_fail++; $display("FAIL gaps_vld[cyc %0d]: got %b want %b", cyc, vo1, pv); end
      n_checks++; if (lo1 !== pl) begin n_fail++; $display("FAIL gaps_last[cyc %0d]: got %b want %b", cyc, lo1, pl); end
      if (pv) begin
        n_checks++; if (dout1[0] !== pd) begin n_fail++; $display("FAIL gaps_data[cyc %0d]: got %h want %h", cyc, dout1[0], pd); end
      end
      if (vo1) outs[pimg]++;
      if (lo1) lasts[pimg]++;
      if (sent < 24 && $urandom_range(0, 1) == 1) begin
        vld1    = 1'b1;
        din1[0] = 8'(sent % 8);
        pv      = (sent % 2 == 1);
        pd      = 8'(sent % 8);
        pl      = (sent % 8 == 7);
        pimg    = sent / 8;
        sent++;
      end else begin
        vld1 = 1'b0;
        pv   = 1'b0;
        pl   = 1'b0;
      end
    end
    vld1 = 1'b0;
    n_checks++; if (sent != 24 || cyc >= 600) begin n_fail++; $display("FAIL gaps_timeout: sent %0d in %0d cycles, want 24 within 600", sent, cyc); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (outs[k] != 4)  begin n_fail++; $display("FAIL gaps_outs[img %0d]: got %0d want 4", k, outs[k]); end
      n_checks++; if (lasts[k] != 1) begin n_fail++; $display("FAIL gaps_lasts[img %0d]: got %0d want 1", k, lasts[k]); end
    end
  endtask

  // Lanes [3..0] ch0 = 2,-1,4,6 -> out[1]=2, out[0]=6; second cycle ends the image.
  task automatic test_tp4();
    apply_reset();
    vld4 = 1'b1;
    din4 = {8'h02, 8'h0F, 8'h04, 8'h06};
    @(negedge clk);
    n_checks++; if (vo4 !== 1'b1)      begin n_fail++; $display("FAIL tp4_vld0: got %b want 1", vo4); end
    n_checks++; if (dout4[1] !== 8'h02) begin n_fail++; $display("FAIL tp4_lane1: got %h want 02", dout4[1]); end
    n_checks++; if (dout4[0] !== 8'h06) begin n_fail++; $display("FAIL tp4_lane0: got %h want 06", dout4[0]); end
    n_checks++; if (lo4 !== 1'b0)      begin n_fail++; $display("FAIL tp4_last0: got %b want 0", lo4); end
    // ch1/ch0 mixed: {1,1} vs {3,-1} -> {3,1}; {-1,0} vs {-8,1} -> {-1,1}
    din4 = {8'h11, 8'h3F, 8'hF0, 8'h81};
    @(negedge clk);
    vld4 = 1'b0;
    n_checks++; if (dout4[1] !== 8'h31) begin n_fail++; $display("FAIL tp4_b_lane1: got %h want 31", dout4[1]); end
    n_checks++; if (dout4[0] !== 8'hF1) begin n_fail++; $display("FAIL tp4_b_lane0: got %h want F1", dout4[0]); end
    n_checks++; if (lo4 !== 1'b1)      begin n_fail++; $display("FAIL tp4_last1: got %b want 1", lo4); end
    @(negedge clk);
    n_checks++; if (vo4 !== 1'b0) begin n_fail++; $display("FAIL tp4_vld_drop: got %b want 0", vo4); end
    n_checks++; if (lo4 !== 1'b0) begin n_fail++; $display("FAIL tp4_last_drop: got %b want 0", lo4); end
  endtask

  // (-8,7)->7, (-1,-2)->-1, (7,7)->7, mixed {ch1=-4,ch0=3} vs {3,-4} -> {3,3}.
  task automatic test_signed();
    apply_reset();
    vld4 = 1'b1;
    din4 = {8'h08, 8'h07, 8'h0F, 8'h0E};
    @(negedge clk);
    n_checks++; if (dout4[1] !== 8'h07) begin n_fail++; $display("FAIL signed_m8_7: got %h want 07", dout4[1]); end
    n_checks++; if (dout4[0] !== 8'h0F) begin n_fail++; $display("FAIL signed_m1_m2: got %h want 0F", dout4[0]); end
    din4 = {8'h07, 8'h07, 8'hC3, 8'h3C};
    @(negedge clk);
    vld4 = 1'b0;
    n_checks++; if (dout4[1] !== 8'h07) begin n_fail++; $display("FAIL signed_tie: got %h want 07", dout4[1]); end
    n_checks++; if (dout4[0] !== 8'h33) begin n_fail++; $display("FAIL signed_mixed: got %h want 33", dout4[0]); end
    n_checks++; if (vo4 !== 1'b1)      begin n_fail++; $display("FAIL signed_vld: got %b want 1", vo4); end
  endtask

  task automatic test_reset_mid_pair();
    apply_reset();
    // Finish one image so vld_out and last_out are both high, then reset off-edge.
    for (int i = 0; i < 8; i++) begin
      vld1    = 1'b1;
      din1[0] = 8'(i);
      @(negedge clk);
    end
    vld1 = 1'b0;
    n_checks++; if (vo1 !== 1'b1 || lo1 !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got vld %b last %b want 1 1", vo1, lo1); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (vo1 !== 1'b0)   begin n_fail++; $display("FAIL rst_async_vld: got %b want 0", vo1); end
    n_checks++; if (lo1 !== 1'b0)   begin n_fail++; $display("FAIL rst_async_last: got %b want 0", lo1); end
    n_checks++; if (dout1 !== 8'h0) begin n_fail++; $display("FAIL rst_async_data: got %h want 00", dout1); end
    #9 rst = 1'b0;
    // One lone sample of 6, then an off-edge one-cycle reset discards it.
    @(negedge clk);
    vld1    = 1'b1;
    din1[0] = 8'h06;
    @(negedge clk);
    vld1 = 1'b0;
    n_checks++; if (vo1 !== 1'b0) begin n_fail++; $display("FAIL rst_lone_vld: got %b want 0", vo1); end
    #3 rst = 1'b1;
    #10 rst = 1'b0;
    @(negedge clk);
    vld1    = 1'b1;
    din1[0] = 8'h01;
    @(negedge clk);
    din1[0] = 8'h02;
    n_checks++; if (vo1 !== 1'b0) begin n_fail++; $display("FAIL rst_discard_vld: got %b want 0", vo1); end
    @(negedge clk);
    n_checks++; if (vo1 !== 1'b1)      begin n_fail++; $display("FAIL rst_first_vld: got %b want 1", vo1); end
    n_checks++; if (dout1[0] !== 8'h02) begin n_fail++; $display("FAIL rst_first_data: got %h want 02", dout1[0]); end
    n_checks++; if (lo1 !== 1'b0)      begin n_fail++; $display("FAIL rst_first_last: got %b want 0", lo1); end
    // Three more pairs: counter restarted at 0, so last_out lands on the 4th output.
    for (int j = 0; j <= 6; j++) begin
      if (j < 6) begin vld1 = 1'b1; din1[0] = 8'h00; end
      else vld1 = 1'b0;
      @(negedge clk);
      if (j < 6) begin
        n_checks++; if (vo1 !== (j % 2 == 1)) begin n_fail++; $display("FAIL rst_cnt_vld[%0d]: got %b want %b", j, vo1, (j % 2 == 1)); end
        n_checks++; if (lo1 !== (j == 5))     begin n_fail++; $display("FAIL rst_cnt_last[%0d]: got %b want %b", j, lo1, (j == 5)); end
      end
    end
  endtask

  // THROUGHPUT=2, 1000 cycles of continuous input across ~15 images.
  task automatic test_back_to_back();
    logic signed [3:0] a0, b0, a1, b1;
    logic [7:0]        expd;
    apply_reset();
    for (int i = 0; i < 1000; i++) begin
      a0 = 4'(i * 5);
      b0 = 4'(i);
      a1 = 4'(i * 7);
      b1 = 4'(i + 3);
      vld2    = 1'b1;
      din2[1] = {a1, a0};
      din2[0] = {b1, b0};
      expd    = {(a1 > b1) ? a1 : b1, (a0 > b0) ? a0 : b0};
      @(negedge clk);
      n_checks++; if (vo2 !== 1'b1)        begin n_fail++; $display("FAIL b2b_vld[%0d]: got %b want 1", i, vo2); end
      n_checks++; if (lo2 !== (i % 64 == 63)) begin n_fail++; $display("FAIL b2b_last[%0d]: got %b want %b", i, lo2, (i % 64 == 63)); end
      n_checks++; if (dout2[0] !== expd)   begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, dout2[0], expd); end
    end
    vld2 = 1'b0;
    @(negedge clk);
    n_checks++; if (vo2 !== 1'b0) begin n_fail++; $display("FAIL b2b_end_vld: got %b want 0", vo2); end
  endtask

  initial begin
    test_reset();
    test_pairs_tp1();
    test_gaps();
    test_tp4();
    test_signed();
    test_reset_mid_pair();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool_stream.md
Name: maxpool_stream

Overview:
- Stride-2, size-2 max-pool along the sequence axis, on the output side of a conv layer.
- The windower widens a stream by adding boundary context before a conv; this block contracts the conv result stream by half before the next layer.
- Consumes the same vld_in/data_in lane format the windower accepts, and emits a half-length image in the same format.
- Tracks image position so that pairing never crosses an image boundary, and flags the last output of each image.

Parameters:
- NO_CH, 8, channels per sample.
- BW, 4, bits per channel; two's-complement signed.
- LOG2_IMG_SIZE, 7, input image length is 2^LOG2_IMG_SIZE samples (at least 2).
- THROUGHPUT, 1, input samples per valid cycle; must be 1 or an even number.
- OUT_TP, derived: THROUGHPUT/2 if THROUGHPUT>=2, else 1. Output samples per valid output cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- vld_in  in  1  data_in holds THROUGHPUT new samples this cycle.
- data_in  in  [NO_CH*BW-1:0] x THROUGHPUT  input lanes; lane THROUGHPUT-1 is the earliest sample, channel c is at bits [c*BW +: BW].
- vld_out  out  1  data_out holds OUT_TP pooled samples.
- data_out  out  [NO_CH*BW-1:0] x OUT_TP  output lanes; lane OUT_TP-1 is the earliest sample.
- last_out  out  1  high with vld_out on the final pooled output cycle of an image.

Behaviour:
- Reset (async, rst=1):
  - vld_out=0, last_out=0, data_out all lanes 0.
  - Phase bit, hold register and position counters cleared.
  - Any partially paired sample is discarded; the next vld_in after release is image sample 0.
- Pool op: max_c(a,b) = per-channel signed maximum of BW-bit fields. Pure compare/select, no width growth. On a tie, either operand may be taken (values are identical).
- THROUGHPUT>=2:
  - On a vld_in cycle, out lane k = max(in lane 2k+1, in lane 2k), k = 0..OUT_TP-1.
  - Result is registered: vld_out=1 exactly 1 cycle after vld_in.
  - No internal state besides the position counter.
- THROUGHPUT==1:
  - A phase bit toggles on every vld_in.
  - Phase 0: capture data_in into the hold register; no output.
  - Phase 1: register max(hold, data_in); vld_out=1 on the next cycle.
  - Latency is 1 cycle after the second sample of each pair.
- Gaps: vld_in may drop for any number of cycles, including between the two samples of a pair. The hold register and phase are retained unchanged across gaps.
- vld_out is a 1-cycle pulse per produced output; there is no backpressure, and the downstream must accept every cycle.
- data_out holds its last value when vld_out=0. The bench checks data_out only when vld_out=1.
- Position counter:
  - out_cnt, LOG2_IMG_SIZE-1 bits, counts output samples within an image.
  - Increments by OUT_TP per vld_out and wraps to 0 at 2^(LOG2_IMG_SIZE-1).
  - last_out=1 when the output cycle covers index 2^(LOG2_IMG_SIZE-1)-1.
- Image boundary:
  - Image length is even, so phase is 0 at every boundary by construction.
  - On wrap, phase is forced to 0 as a guard.
- Back-to-back images: no dead cycle is required; sample 0 of the next image may arrive the cycle after the last sample of the current one.
- Simultaneous vld_in and output register update: the new pair result overwrites data_out in the same edge that vld_out re-asserts. No bubbles.

Decomposition:
- Shared package maxpool_pkg:
  - localparams OUT_TP and OUT_LEN = 2^(LOG2_IMG_SIZE-1).
  - Function smax_bw(a,b): per-channel signed max over an NO_CH*BW vector.
- One sub-module, chan_max2: combinational two-input per-channel signed max for one sample pair. It is instantiated OUT_TP times, or once for THROUGHPUT==1.
- Phase, hold, counter and output registers live in the top.

Test Plan:
1. THROUGHPUT=1, NO_CH=2, BW=4, LOG2_IMG_SIZE=3. Input channel-0 sequence 1,5,-3,-7,7,-8,0,0 with channel 1 = 0 throughout, vld_in held high -> outputs 5,-3,7,0 on ch0, one cycle after each odd sample; last_out on the 4th output only.
2. Same config, vld_in randomised at 50% (including gaps inside pairs) over 3 images of ramp data 0..7 -> per image, outputs 1,3,5,7; exactly 4 vld_out and 1 last_out per image; never an output pairing across images.
3. THROUGHPUT=4: one cycle with lanes [3..0] = 2,-1,4,6 (ch0) -> next cycle vld_out=1, data_out[1]=2, data_out[0]=6.
4. Signed-edge check, BW=4: pairs (-8,7), (-1,-2), (7,7) -> 7, -1, 7. Per channel, mixed in one sample: ch0 pair (3,-4) -> 3 while ch1 pair (-4,3) -> 3.
5. Reset mid-pair, THROUGHPUT=1: feed one sample of value 6, assert rst asynchronously (not clock-aligned) for 1 cycle, then feed 1,2 -> vld_out/last_out drop immediately; the single post-reset output is 2 (6 discarded); out_cnt restarted at 0.
6. Continuous back-to-back images, THROUGHPUT=2, LOG2_IMG_SIZE=7, 1000 cycles with vld_in always high -> one output per cycle after 1-cycle latency; last_out every 64th output.
